// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported memory between instruction fetch (IF) and
//   load/store (LSU). Uses a req/gnt/rvalid handshake with one transaction
//   outstanding at a time. LSU has fixed priority. A streak counter lets IF
//   win once LSU has won MAX_DSTREAK times in a row while IF was waiting.
//
// Ports
//   clk_i, rst_i                       clock, async active-high reset
//   instr_req_i/addr_i                 IF request and address (read only)
//   instr_gnt_o/rvalid_o/rdata_o       IF grant, response valid, read data
//   data_req_i/we_i/be_i/addr_i/wdata_i  LSU request and payload
//   data_gnt_o/rvalid_o/rdata_o        LSU grant, response valid, read data
//   mem_req_o/we_o/be_o/addr_o/wdata_o memory request and payload
//   mem_gnt_i/rvalid_i/rdata_i         memory grant and response
//   proto_err_o                        sticky: a response arrived with none outstanding
//
// Grants and responses are forwarded combinationally from the memory port.
module mem_port_arbiter #(
    parameter int unsigned MEM_AW      = 32,
    parameter int unsigned MEM_DW      = 32,
    parameter int unsigned MAX_DSTREAK = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  instr_req_i,
    input  logic [MEM_AW-1:0]     instr_addr_i,
    output logic                  instr_gnt_o,
    output logic                  instr_rvalid_o,
    output logic [MEM_DW-1:0]     instr_rdata_o,
    input  logic                  data_req_i,
    input  logic                  data_we_i,
    input  logic [MEM_DW/8-1:0]   data_be_i,
    input  logic [MEM_AW-1:0]     data_addr_i,
    input  logic [MEM_DW-1:0]     data_wdata_i,
    output logic                  data_gnt_o,
    output logic                  data_rvalid_o,
    output logic [MEM_DW-1:0]     data_rdata_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [MEM_DW/8-1:0]   mem_be_o,
    output logic [MEM_AW-1:0]     mem_addr_o,
    output logic [MEM_DW-1:0]     mem_wdata_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [MEM_DW-1:0]     mem_rdata_i,
    output logic                  proto_err_o
);

    localparam int unsigned MEM_BW = MEM_DW / 8;
    // MAX_DSTREAK is limited to 1..15, so four bits always suffice.
    localparam int unsigned DSW    = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_LSU = 1'b1
    } owner_e;

    typedef struct packed {
        logic              we;
        logic [MEM_BW-1:0] be;
        logic [MEM_AW-1:0] addr;
        logic [MEM_DW-1:0] wdata;
    } mem_cmd_t;

    state_e          state_q, state_d;
    owner_e          owner_q, owner_d;
    logic [DSW-1:0]  dstreak_q, dstreak_d;
    logic            proto_err_q, proto_err_d;

    logic            win_lsu_c;
    logic            sel_lsu_c;
    logic            grant_c;
    logic            mem_req_c;
    logic            instr_gnt_c, data_gnt_c;
    logic            instr_rvalid_c, data_rvalid_c;
    mem_cmd_t        if_cmd_c, lsu_cmd_c, cmd_c;

    // LSU wins unless IF is waiting and the streak limit has been reached.
    assign win_lsu_c = data_req_i && !(instr_req_i && (dstreak_q == DSW'(MAX_DSTREAK)));

    // Per-requester memory payloads; IF is always a full-word read.
    always_comb begin
        if_cmd_c       = '0;
        if_cmd_c.we    = 1'b0;
        if_cmd_c.be    = '1;
        if_cmd_c.addr  = instr_addr_i;
        if_cmd_c.wdata = '0;

        lsu_cmd_c       = '0;
        lsu_cmd_c.we    = data_we_i;
        lsu_cmd_c.be    = data_be_i;
        lsu_cmd_c.addr  = data_addr_i;
        lsu_cmd_c.wdata = data_wdata_i;
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_IF;
            dstreak_q   <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            dstreak_q   <= dstreak_d;
            proto_err_q <= proto_err_d;
        end
    end

    // Next-state and handshake decode.
    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        proto_err_d    = proto_err_q;
        sel_lsu_c      = (owner_q == OWN_LSU);
        grant_c        = 1'b0;
        mem_req_c      = 1'b0;
        instr_gnt_c    = 1'b0;
        data_gnt_c     = 1'b0;
        instr_rvalid_c = 1'b0;
        data_rvalid_c  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                sel_lsu_c = win_lsu_c;
                if (instr_req_i || data_req_i) begin
                    mem_req_c = 1'b1;
                    owner_d   = win_lsu_c ? OWN_LSU : OWN_IF;
                    if (mem_gnt_i) begin
                        grant_c = 1'b1;
                        state_d = ST_WAIT;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
                if (mem_rvalid_i) begin
                    proto_err_d = 1'b1;
                end
            end
            ST_REQ: begin
                // Locked to the latched owner, even if it drops its request.
                mem_req_c = 1'b1;
                if (mem_gnt_i) begin
                    grant_c = 1'b1;
                    state_d = ST_WAIT;
                end
                if (mem_rvalid_i) begin
                    proto_err_d = 1'b1;
                end
            end
            ST_WAIT: begin
                if (mem_rvalid_i) begin
                    if (owner_q == OWN_LSU) begin
                        data_rvalid_c = 1'b1;
                    end else begin
                        instr_rvalid_c = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (grant_c) begin
            if (sel_lsu_c) begin
                data_gnt_c = 1'b1;
            end else begin
                instr_gnt_c = 1'b1;
            end
        end
    end

    // Streak counter: counts LSU grants that left IF waiting, saturating.
    always_comb begin
        dstreak_d = dstreak_q;
        if (grant_c) begin
            if (sel_lsu_c && instr_req_i) begin
                if (dstreak_q < DSW'(MAX_DSTREAK)) begin
                    dstreak_d = dstreak_q + DSW'(1);
                end
            end else begin
                dstreak_d = '0;
            end
        end
    end

    assign cmd_c = sel_lsu_c ? lsu_cmd_c : if_cmd_c;

    assign mem_we_o    = cmd_c.we;
    assign mem_be_o    = cmd_c.be;
    assign mem_addr_o  = cmd_c.addr;
    assign mem_wdata_o = cmd_c.wdata;

    // Handshake outputs are held low for as long as reset is asserted.
    assign mem_req_o      = mem_req_c      & ~rst_i;
    assign instr_gnt_o    = instr_gnt_c    & ~rst_i;
    assign data_gnt_o     = data_gnt_c     & ~rst_i;
    assign instr_rvalid_o = instr_rvalid_c & ~rst_i;
    assign data_rvalid_o  = data_rvalid_c  & ~rst_i;

    assign instr_rdata_o = mem_rdata_i;
    assign data_rdata_o  = mem_rdata_i;
    assign proto_err_o   = proto_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam logic [31:0] IA = 32'h0000_0100;
    localparam logic [31:0] DA = 32'h0000_0200;
    localparam logic [31:0] WD = 32'hA5A5_A5A5;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        instr_req_i = 1'b0;
    logic [31:0] instr_addr_i = IA;
    logic        instr_gnt_o, instr_rvalid_o;
    logic [31:0] instr_rdata_o;
    logic        data_req_i = 1'b0;
    logic        data_we_i = 1'b0;
    logic [3:0]  data_be_i = 4'h0;
    logic [31:0] data_addr_i = DA;
    logic [31:0] data_wdata_i = WD;
    logic        data_gnt_o, data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_gnt_i = 1'b0;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = 32'h0;
    logic        proto_err_o;

    int n_tests = 0;
    int n_fail  = 0;

    mem_port_arbiter #(.MEM_AW(32), .MEM_DW(32), .MAX_DSTREAK(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i),
        .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o),
        .instr_rdata_o(instr_rdata_o),
        .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
        .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
        .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
        .data_rdata_o(data_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i(mem_rdata_i), .proto_err_o(proto_err_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        ireq, dreq, we;
        logic [3:0]  be;
        logic        gnt, rv;
        logic [31:0] rdata;
        logic        e_mreq, e_we;
        logic [3:0]  e_be;
        logic [31:0] e_addr;
        logic        e_igt, e_dgt, e_irv, e_drv, e_perr;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs [NV];

    function automatic vec_t mk(
        input logic ireq, input logic dreq, input logic we, input logic [3:0] be,
        input logic gnt, input logic rv, input logic [31:0] rdata,
        input logic e_mreq, input logic e_we, input logic [3:0] e_be,
        input logic [31:0] e_addr, input logic e_igt, input logic e_dgt,
        input logic e_irv, input logic e_drv, input logic e_perr);
        vec_t v;
        v.ireq = ireq; v.dreq = dreq; v.we = we; v.be = be;
        v.gnt = gnt; v.rv = rv; v.rdata = rdata;
        v.e_mreq = e_mreq; v.e_we = e_we; v.e_be = e_be; v.e_addr = e_addr;
        v.e_igt = e_igt; v.e_dgt = e_dgt; v.e_irv = e_irv; v.e_drv = e_drv;
        v.e_perr = e_perr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge.
    task automatic drive(input logic ireq, input logic dreq, input logic we,
                         input logic [3:0] be, input logic gnt, input logic rv,
                         input logic [31:0] rdata);
        @(posedge clk_i);
        #1;
        instr_req_i  = ireq;
        data_req_i   = dreq;
        data_we_i    = we;
        data_be_i    = be;
        mem_gnt_i    = gnt;
        mem_rvalid_i = rv;
        mem_rdata_i  = rdata;
    endtask

    task automatic chk_gated(input string tag);
        chk({tag, " mem_req"},     64'(mem_req_o),      64'(0));
        chk({tag, " instr_gnt"},   64'(instr_gnt_o),    64'(0));
        chk({tag, " data_gnt"},    64'(data_gnt_o),     64'(0));
        chk({tag, " instr_rvalid"},64'(instr_rvalid_o), 64'(0));
        chk({tag, " data_rvalid"}, 64'(data_rvalid_o),  64'(0));
        chk({tag, " proto_err"},   64'(proto_err_o),    64'(0));
    endtask

    task automatic do_reset(input string tag);
        drive(1'b1, 1'b1, 1'b1, 4'hF, 1'b1, 1'b1, 32'h1);
        rst_i = 1'b1;
        @(negedge clk_i);
        chk_gated(tag);
        drive(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 32'h0);
        rst_i = 1'b0;
    endtask

    logic exp_lsu [10];
    logic [31:0] exp_wd;

    initial begin
        //            ireq dreq we be    gnt rv rdata           | mreq we be   addr igt dgt irv drv perr
        vecs[0]  = mk(1,0,0,4'h0, 1,0,32'h0,           1,0,4'hF,IA, 1,0,0,0,0);
        vecs[1]  = mk(0,0,0,4'h0, 0,0,32'h0,           0,0,4'h0,IA, 0,0,0,0,0);
        vecs[2]  = mk(0,0,0,4'h0, 0,1,32'hDEADBEEF,    0,0,4'h0,IA, 0,0,1,0,0);
        vecs[3]  = mk(1,1,1,4'h3, 0,0,32'h0,           1,1,4'h3,DA, 0,0,0,0,0);
        vecs[4]  = mk(1,1,1,4'h3, 0,0,32'h0,           1,1,4'h3,DA, 0,0,0,0,0);
        vecs[5]  = mk(1,1,1,4'h3, 0,0,32'h0,           1,1,4'h3,DA, 0,0,0,0,0);
        vecs[6]  = mk(1,1,1,4'h3, 1,0,32'h0,           1,1,4'h3,DA, 0,1,0,0,0);
        vecs[7]  = mk(1,0,0,4'h0, 0,0,32'h0,           0,0,4'h0,IA, 0,0,0,0,0);
        vecs[8]  = mk(1,0,0,4'h0, 0,1,32'h0,           0,0,4'h0,IA, 0,0,0,1,0);
        vecs[9]  = mk(1,0,0,4'h0, 1,0,32'h0,           1,0,4'hF,IA, 1,0,0,0,0);
        vecs[10] = mk(0,0,0,4'h0, 0,1,32'h12345678,    0,0,4'h0,IA, 0,0,1,0,0);
        vecs[11] = mk(0,0,0,4'h0, 0,1,32'h0,           0,0,4'h0,IA, 0,0,0,0,0);
        vecs[12] = mk(0,0,0,4'h0, 0,0,32'h0,           0,0,4'h0,IA, 0,0,0,0,1);
        vecs[13] = mk(0,1,0,4'hF, 1,0,32'h0,           1,0,4'hF,DA, 0,1,0,0,1);
        vecs[14] = mk(0,0,0,4'h0, 0,1,32'hCAFEF00D,    0,0,4'h0,IA, 0,0,0,1,1);
        vecs[15] = mk(1,0,0,4'h0, 0,0,32'h0,           1,0,4'hF,IA, 0,0,0,0,1);
        vecs[16] = mk(1,0,0,4'h0, 1,1,32'h5555,        1,0,4'hF,IA, 1,0,0,0,1);
        vecs[17] = mk(0,0,0,4'h0, 0,1,32'h6666,        0,0,4'h0,IA, 0,0,1,0,1);
        vecs[18] = mk(0,1,1,4'hC, 0,0,32'h0,           1,1,4'hC,DA, 0,0,0,0,1);
        vecs[19] = mk(1,0,1,4'hC, 0,0,32'h0,           1,1,4'hC,DA, 0,0,0,0,1);
        vecs[20] = mk(1,0,1,4'hC, 1,0,32'h0,           1,1,4'hC,DA, 0,1,0,0,1);
        vecs[21] = mk(0,0,0,4'h0, 0,1,32'h77,          0,0,4'h0,IA, 0,0,0,1,1);

        exp_lsu = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

        // Outputs held low during reset even with all requests active.
        instr_req_i = 1'b1; data_req_i = 1'b1; mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1;
        @(negedge clk_i);
        chk_gated("reset0");
        drive(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 32'h0);
        rst_i = 1'b0;

        // Directed single-cycle vectors.
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].ireq, vecs[i].dreq, vecs[i].we, vecs[i].be,
                  vecs[i].gnt, vecs[i].rv, vecs[i].rdata);
            @(negedge clk_i);
            chk($sformatf("v%0d mem_req", i),      64'(mem_req_o),      64'(vecs[i].e_mreq));
            chk($sformatf("v%0d instr_gnt", i),    64'(instr_gnt_o),    64'(vecs[i].e_igt));
            chk($sformatf("v%0d data_gnt", i),     64'(data_gnt_o),     64'(vecs[i].e_dgt));
            chk($sformatf("v%0d instr_rvalid", i), 64'(instr_rvalid_o), 64'(vecs[i].e_irv));
            chk($sformatf("v%0d data_rvalid", i),  64'(data_rvalid_o),  64'(vecs[i].e_drv));
            chk($sformatf("v%0d proto_err", i),    64'(proto_err_o),    64'(vecs[i].e_perr));
            chk($sformatf("v%0d instr_rdata", i),  64'(instr_rdata_o),  64'(vecs[i].rdata));
            chk($sformatf("v%0d data_rdata", i),   64'(data_rdata_o),   64'(vecs[i].rdata));
            if (vecs[i].e_mreq) begin
                exp_wd = (vecs[i].e_addr == DA) ? WD : 32'h0;
                chk($sformatf("v%0d mem_we", i),    64'(mem_we_o),    64'(vecs[i].e_we));
                chk($sformatf("v%0d mem_be", i),    64'(mem_be_o),    64'(vecs[i].e_be));
                chk($sformatf("v%0d mem_addr", i),  64'(mem_addr_o),  64'(vecs[i].e_addr));
                chk($sformatf("v%0d mem_wdata", i), 64'(mem_wdata_o), 64'(exp_wd));
            end
        end

        // Sticky error clears only on reset.
        do_reset("reset1");
        @(negedge clk_i);
        chk("post-reset proto_err", 64'(proto_err_o), 64'(0));

        // Both requesting continuously: starvation guard interleaves IF.
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 1'b1, 1'b0, 4'hF, 1'b1, 1'b0, 32'h0);
            @(negedge clk_i);
            chk($sformatf("streak%0d data_gnt", k),  64'(data_gnt_o),  64'(exp_lsu[k]));
            chk($sformatf("streak%0d instr_gnt", k), 64'(instr_gnt_o), 64'(!exp_lsu[k]));
            chk($sformatf("streak%0d mem_addr", k),  64'(mem_addr_o),  64'(exp_lsu[k] ? DA : IA));
            drive(1'b1, 1'b1, 1'b0, 4'hF, 1'b0, 1'b1, 32'(k));
            @(negedge clk_i);
            chk($sformatf("streak%0d mem_req wait", k), 64'(mem_req_o),      64'(0));
            chk($sformatf("streak%0d data_rvalid", k),  64'(data_rvalid_o),  64'(exp_lsu[k]));
            chk($sformatf("streak%0d instr_rvalid", k), 64'(instr_rvalid_o), 64'(!exp_lsu[k]));
        end

        // Reset while waiting for a response, then a stale response and a new IF read.
        drive(1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 32'h0);
        @(negedge clk_i);
        chk("midrst igt", 64'(instr_gnt_o), 64'(1));
        for (int r = 0; r < 2; r++) begin
            drive(1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 32'h99);
            rst_i = 1'b1;
            @(negedge clk_i);
            chk_gated($sformatf("midrst%0d", r));
        end
        drive(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 32'h99);
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("stale instr_rvalid", 64'(instr_rvalid_o), 64'(0));
        chk("stale proto_err now", 64'(proto_err_o), 64'(0));
        drive(1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 32'h0);
        @(negedge clk_i);
        chk("newif igt", 64'(instr_gnt_o), 64'(1));
        chk("newif addr", 64'(mem_addr_o), 64'(IA));
        chk("stale proto_err set", 64'(proto_err_o), 64'(1));
        drive(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 32'hBEEF0001);
        @(negedge clk_i);
        chk("newif irv", 64'(instr_rvalid_o), 64'(1));
        chk("newif drv", 64'(data_rvalid_o), 64'(0));
        chk("newif rdata", 64'(instr_rdata_o), 64'(32'hBEEF0001));
        drive(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk_i);
        chk("final proto_err held", 64'(proto_err_o), 64'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
